// File: rtl/block_move_sequencer.sv
// block_move_sequencer
//   Upstream control stage for the 8x8 block clearer. A move request first
//   starts the clearer at the old block position and waits for it to finish
//   (unless skip_clear is set). It then paints the block at the new position
//   with its own row-major draw counter. The clearer's pixel stream and the
//   internal draw stream share one registered pixel-write port to the VGA
//   adapter.
//
// Ports
//   clock, reset_n          : rising-edge clock, synchronous active-low reset
//   go, skip_clear          : move request (IDLE only) / no clear phase
//   old_x, old_y            : top-left of block to erase (sampled with go)
//   new_x, new_y, new_colour: top-left and colour of block to draw
//   clr_start               : one-cycle start pulse to clearer
//   clr_ref_x, clr_ref_y    : latched old position to clearer
//   clr_x/y/colour/we       : clearer pixel stream
//   clr_done                : clearer finished (level)
//   vga_x/y/colour/we       : registered pixel-write port
//   busy                    : high while a move is in progress
//   done                    : one-cycle pulse at end of a move
module block_move_sequencer #(
  parameter int unsigned SIZE = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       go,
  input  logic       skip_clear,
  input  logic [7:0] old_x,
  input  logic [6:0] old_y,
  input  logic [7:0] new_x,
  input  logic [6:0] new_y,
  input  logic [2:0] new_colour,
  output logic       clr_start,
  output logic [7:0] clr_ref_x,
  output logic [6:0] clr_ref_y,
  input  logic [7:0] clr_x,
  input  logic [6:0] clr_y,
  input  logic [2:0] clr_colour,
  input  logic       clr_we,
  input  logic       clr_done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_we,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LAST = 4'(SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR_START,
    CLR_WAIT,
    DRAW,
    FIN
  } state_t;

  state_t     state_q, state_d;
  logic       wait_first_q, wait_first_d;
  logic [3:0] xi_q, xi_d;
  logic [3:0] yi_q, yi_d;
  logic [7:0] clr_ref_x_q, clr_ref_x_d;
  logic [6:0] clr_ref_y_q, clr_ref_y_d;
  logic [7:0] new_x_q, new_x_d;
  logic [6:0] new_y_q, new_y_d;
  logic [2:0] colour_q, colour_d;
  logic       clr_start_q, clr_start_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       vga_we_q, vga_we_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Next-state, counters and latched request.
  always_comb begin
    state_d      = state_q;
    wait_first_d = 1'b0;
    xi_d         = xi_q;
    yi_d         = yi_q;
    clr_ref_x_d  = clr_ref_x_q;
    clr_ref_y_d  = clr_ref_y_q;
    new_x_d      = new_x_q;
    new_y_d      = new_y_q;
    colour_d     = colour_q;

    unique case (state_q)
      IDLE: begin
        if (go) begin
          clr_ref_x_d = old_x;
          clr_ref_y_d = old_y;
          new_x_d     = new_x;
          new_y_d     = new_y;
          colour_d    = new_colour;
          xi_d        = '0;
          yi_d        = '0;
          state_d     = skip_clear ? DRAW : CLR_START;
        end
      end
      CLR_START: begin
        // Marks the first CLR_WAIT cycle, where clr_done is still stale.
        wait_first_d = 1'b1;
        state_d      = CLR_WAIT;
      end
      CLR_WAIT: begin
        if (!wait_first_q && clr_done) begin
          xi_d    = '0;
          yi_d    = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (xi_q == LAST) begin
          xi_d = '0;
          if (yi_q == LAST) begin
            yi_d    = '0;
            state_d = FIN;
          end else begin
            yi_d = yi_q + 4'd1;
          end
        end else begin
          xi_d = xi_q + 4'd1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs: control pulses follow the next state, while the
  // pixel port follows the source selected by the current state, giving
  // the one-cycle lag of vga_* behind the state.
  always_comb begin
    clr_start_d  = (state_d == CLR_START);
    done_d       = (state_q == FIN);
    // Held through the done cycle so busy and done fall together.
    busy_d       = (state_d != IDLE) || done_d;

    vga_x_d      = '0;
    vga_y_d      = '0;
    vga_colour_d = '0;
    vga_we_d     = 1'b0;

    unique case (state_q)
      CLR_START, CLR_WAIT: begin
        vga_x_d      = clr_x;
        vga_y_d      = clr_y;
        vga_colour_d = clr_colour;
        vga_we_d     = clr_we;
      end
      DRAW: begin
        vga_x_d      = new_x_q + {4'b0000, xi_q};
        vga_y_d      = new_y_q + {3'b000, yi_q};
        vga_colour_d = colour_q;
        vga_we_d     = 1'b1;
      end
      default: begin
        vga_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wait_first_q <= 1'b0;
      xi_q         <= '0;
      yi_q         <= '0;
      clr_ref_x_q  <= '0;
      clr_ref_y_q  <= '0;
      new_x_q      <= '0;
      new_y_q      <= '0;
      colour_q     <= '0;
      clr_start_q  <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_first_q <= wait_first_d;
      xi_q         <= xi_d;
      yi_q         <= yi_d;
      clr_ref_x_q  <= clr_ref_x_d;
      clr_ref_y_q  <= clr_ref_y_d;
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
      colour_q     <= colour_d;
      clr_start_q  <= clr_start_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_we_q     <= vga_we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign clr_start  = clr_start_q;
  assign clr_ref_x  = clr_ref_x_q;
  assign clr_ref_y  = clr_ref_y_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_we     = vga_we_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_block_move_sequencer.sv
module tb_block_move_sequencer;

  logic       clock;
  logic       reset_n;
  logic       go;
  logic       skip_clear;
  logic [7:0] old_x;
  logic [6:0] old_y;
  logic [7:0] new_x;
  logic [6:0] new_y;
  logic [2:0] new_colour;
  logic       clr_start;
  logic [7:0] clr_ref_x;
  logic [6:0] clr_ref_y;
  logic [7:0] clr_x;
  logic [6:0] clr_y;
  logic [2:0] clr_colour;
  logic       clr_we;
  logic       clr_done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_we;
  logic       busy;
  logic       done;

  int n_cmp;
  int n_fail;

  block_move_sequencer #(.SIZE(8)) dut (
    .clock(clock), .reset_n(reset_n), .go(go), .skip_clear(skip_clear),
    .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y),
    .new_colour(new_colour), .clr_start(clr_start), .clr_ref_x(clr_ref_x),
    .clr_ref_y(clr_ref_y), .clr_x(clr_x), .clr_y(clr_y),
    .clr_colour(clr_colour), .clr_we(clr_we), .clr_done(clr_done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_we(vga_we),
    .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural clearer: on clr_start, writes 64 black pixels row-major at
  // clr_ref, then raises done (level) until the next start.
  logic       cl_active;
  logic [5:0] cl_cnt;
  logic       cl_done;
  logic       stale_mode;

  always @(posedge clock) begin
    if (!reset_n) begin
      cl_active <= 1'b0;
      cl_cnt    <= '0;
      cl_done   <= 1'b1;
    end else if (clr_start) begin
      cl_active <= 1'b1;
      cl_cnt    <= '0;
      cl_done   <= 1'b0;
    end else if (cl_active) begin
      cl_cnt <= cl_cnt + 6'd1;
      if (cl_cnt == 6'd63) begin
        cl_active <= 1'b0;
        cl_done   <= 1'b1;
      end
    end
  end

  assign clr_we     = cl_active && !stale_mode;
  assign clr_done   = stale_mode ? 1'b1 : cl_done;
  assign clr_x      = clr_ref_x + {5'b00000, cl_cnt[2:0]};
  assign clr_y      = clr_ref_y + {4'b0000, cl_cnt[5:3]};
  assign clr_colour = 3'b000;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_clr_start"}, clr_start, 0);
    chk({tag, "_clr_ref_x"}, clr_ref_x, 0);
    chk({tag, "_clr_ref_y"}, clr_ref_y, 0);
    chk({tag, "_vga_x"}, vga_x, 0);
    chk({tag, "_vga_y"}, vga_y, 0);
    chk({tag, "_vga_colour"}, vga_colour, 0);
    chk({tag, "_vga_we"}, vga_we, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  typedef struct {
    logic [7:0] nx;
    logic [6:0] ny;
    logic [2:0] col;
    bit         poke;   // issue a second go mid-draw
    logic [7:0] fx;     // expected first pixel
    logic [6:0] fy;
    logic [7:0] lx;     // expected last pixel
    logic [6:0] ly;
  } vec_t;

  vec_t vecs[3];

  // Skip-clear move: go edge E0, pixel p on vga after edge E(1+p), done after E65.
  task automatic run_draw(input vec_t v);
    logic [7:0] ex;
    logic [6:0] ey;
    go = 1'b1; skip_clear = 1'b1;
    new_x = v.nx; new_y = v.ny; new_colour = v.col;
    old_x = 8'($urandom); old_y = 7'($urandom);
    tick();
    go = 1'b0;
    chk("draw_busy_rise", busy, 1);
    chk("draw_we_lag", vga_we, 0);
    chk("draw_no_clr_start", clr_start, 0);
    for (int p = 0; p < 64; p++) begin
      if (v.poke && p == 30) begin
        go = 1'b1; skip_clear = 1'b1;
        new_x = 8'd99; new_y = 7'd9; new_colour = ~v.col;
      end
      if (p == 31) go = 1'b0;
      tick();
      ex = v.nx + 8'(p % 8);
      ey = v.ny + 7'(p / 8);
      chk("draw_we", vga_we, 1);
      chk("draw_x", vga_x, ex);
      chk("draw_y", vga_y, ey);
      chk("draw_colour", vga_colour, v.col);
      chk("draw_done_low", done, 0);
      if (p == 0) begin
        chk("draw_first_x", vga_x, v.fx);
        chk("draw_first_y", vga_y, v.fy);
      end
      if (p == 63) begin
        chk("draw_last_x", vga_x, v.lx);
        chk("draw_last_y", vga_y, v.ly);
      end
    end
    tick();
    chk("draw_done_65", done, 1);
    chk("draw_we_after", vga_we, 0);
    chk("draw_busy_with_done", busy, 1);
    tick();
    chk("draw_done_once", done, 0);
    chk("draw_busy_fall", busy, 0);
    tick();
    chk("draw_no_queued_go", busy, 0);
    chk("draw_idle_we", vga_we, 0);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    stale_mode = 1'b0;
    vecs[0] = '{nx: 8'd10,  ny: 7'd20,  col: 3'b101, poke: 1'b0,
                fx: 8'd10,  fy: 7'd20,  lx: 8'd17, ly: 7'd27};
    vecs[1] = '{nx: 8'd252, ny: 7'd125, col: 3'b011, poke: 1'b1,
                fx: 8'd252, fy: 7'd125, lx: 8'd3,  ly: 7'd4};
    vecs[2] = '{nx: 8'd0,   ny: 7'd0,   col: 3'b111, poke: 1'b0,
                fx: 8'd0,   fy: 7'd0,   lx: 8'd7,  ly: 7'd7};

    // Reset with garbage inputs
    reset_n = 1'b0; go = 1'b1; skip_clear = 1'b0;
    old_x = 8'hA5; old_y = 7'h5A; new_x = 8'h3C; new_y = 7'h33; new_colour = 3'b110;
    repeat (3) tick();
    chk_all_zero("reset");
    go = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("post_reset_idle", busy, 0);

    // Table-driven skip-clear draws (includes wrap and ignored mid-draw go)
    for (int i = 0; i < 3; i++) run_draw(vecs[i]);

    // Full move with behavioural clearer
    begin
      logic [7:0] px[$];
      logic [6:0] py[$];
      logic [2:0] pc[$];
      logic       p_we;
      logic [7:0] p_x;
      logic [6:0] p_y;
      logic [2:0] p_c;
      int starts, dones, done_c, c;
      starts = 0; dones = 0; done_c = -1;
      go = 1'b1; skip_clear = 1'b0;
      old_x = 8'd40; old_y = 7'd40; new_x = 8'd40; new_y = 7'd48; new_colour = 3'b010;
      tick();
      go = 1'b0;
      p_we = 1'b0; p_x = '0; p_y = '0; p_c = '0;
      c = 0;
      while (c <= 200 && !(done_c >= 0 && c > done_c + 1)) begin
        if (clr_start) begin
          starts++;
          chk("move_start_c", c, 0);
          chk("move_ref_x", clr_ref_x, 40);
          chk("move_ref_y", clr_ref_y, 40);
        end
        if (done) begin dones++; done_c = c; end
        if (c > 0 && p_we) begin
          chk("move_pass_we", vga_we, 1);
          chk("move_pass_x", vga_x, p_x);
          chk("move_pass_y", vga_y, p_y);
          chk("move_pass_col", vga_colour, p_c);
        end
        if (c > 0) chk("move_busy", busy, (done_c >= 0 && c > done_c) ? 0 : 1);
        if (vga_we) begin px.push_back(vga_x); py.push_back(vga_y); pc.push_back(vga_colour); end
        p_we = clr_we; p_x = clr_x; p_y = clr_y; p_c = clr_colour;
        tick();
        c++;
      end
      chk("move_start_count", starts, 1);
      chk("move_done_count", dones, 1);
      chk("move_done_latency", done_c, 131);
      chk("move_pixel_count", px.size(), 128);
      if (px.size() == 128) begin
        for (int k = 0; k < 128; k++) begin
          chk("move_pix_x", px[k], 40 + (k % 8));
          chk("move_pix_y", py[k], (k < 64) ? 40 + (k / 8) : 48 + ((k - 64) / 8));
          chk("move_pix_col", pc[k], (k < 64) ? 0 : 2);
        end
      end
    end

    // Stale clr_done held high: DRAW must not start before the second wait cycle
    begin
      int c;
      stale_mode = 1'b1;
      go = 1'b1; skip_clear = 1'b0;
      old_x = 8'd1; old_y = 7'd2; new_x = 8'd5; new_y = 7'd6; new_colour = 3'b010;
      tick();
      go = 1'b0;
      chk("stale_start", clr_start, 1);
      tick();
      chk("stale_start_once", clr_start, 0);
      chk("stale_we_e1", vga_we, 0);
      tick();
      chk("stale_we_e2", vga_we, 0);
      tick();
      chk("stale_we_e3", vga_we, 0);
      tick();
      chk("stale_we_e4", vga_we, 1);
      chk("stale_x", vga_x, 5);
      chk("stale_y", vga_y, 6);
      c = 4;
      while (!done && c < 200) begin tick(); c++; end
      chk("stale_done_latency", c, 68);
      tick();
      stale_mode = 1'b0;
      tick();
      chk("stale_idle", busy, 0);
    end

    // Reset mid-draw at pixel 20, then a clean move
    go = 1'b1; skip_clear = 1'b1;
    new_x = 8'd30; new_y = 7'd30; new_colour = 3'b001;
    tick();
    go = 1'b0;
    repeat (21) tick();
    chk("mid_pix20_x", vga_x, 34);
    chk("mid_pix20_y", vga_y, 32);
    reset_n = 1'b0;
    tick();
    chk_all_zero("mid_reset");
    reset_n = 1'b1;
    tick();
    chk("mid_reset_idle", busy, 0);
    run_draw(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
